sparse_block_encoder: RTL and testbench
=======================================

Name: sparse_block_encoder

Overview:
Producer side of the bitmask-compressed operand format. Accepts one dense block of BLOCK_LENGTH elements. Emits a bitmask beat, then the non-zero elements packed NUM_OUTPUT per beat, LSB-first. The bitmask marks the dense positions and the beats carry those values in order, which is exactly what the downstream mask filters and the sparse MAC buffer consume.

Parameters:
BLOCK_LENGTH, 16, elements per input block and bitmask width
ELEMENT_WIDTH, 8, bits per element; an element is non-zero when any bit is set
NUM_OUTPUT, 2, max packed elements per data beat
INDEX_BITWIDTH, 5, cursor width; must represent 0..BLOCK_LENGTH
COUNT_BITWIDTH, 2, width of outNumValid; must represent 0..NUM_OUTPUT

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
ivalid  in  1  denseBlock valid
oready  out  1  encoder can accept a block
denseBlock  in  ELEMENT_WIDTH*BLOCK_LENGTH  element i at bits [(i+1)*ELEMENT_WIDTH-1 -: ELEMENT_WIDTH]
ovalid  out  1  output beat valid
iready  in  1  downstream accepts beat
outIsBitmask  out  1  1 = bitmask beat, 0 = data beat
outLast  out  1  final beat of the block
outBitmask  out  BLOCK_LENGTH  bit i = element i non-zero (meaningful on bitmask beat, 0 otherwise)
outData  out  ELEMENT_WIDTH*NUM_OUTPUT  packed values, slot 0 in LSBs, unused slots zero
outNumValid  out  COUNT_BITWIDTH  occupied slots in outData

Behaviour:
- Clocking and reset: single clock `clock`; reset `reset` is synchronous and active-high.
- While reset is sampled high, and in the cycle after: state=IDLE; ovalid, outIsBitmask, outLast, outBitmask, outData, outNumValid = 0; captured block and mask = 0; cursor = 0.
- oready = 1 only in IDLE and not in reset, driven combinationally from state.
- FSM states: IDLE, EMIT_MASK, EMIT_DATA.
- IDLE:
  - On ivalid & oready: register denseBlock; register mask[i] = |element i; cursor = 0; go to EMIT_MASK.
  - First beat is valid in the cycle after acceptance (latency 1).
- EMIT_MASK:
  - ovalid=1, outIsBitmask=1, outBitmask=mask, outData=0, outNumValid=0, outLast=(mask==0).
  - On iready: go to IDLE if mask==0, else EMIT_DATA.
- EMIT_DATA:
  - Select the first min(NUM_OUTPUT, remaining) set mask bits at positions >= cursor, in ascending order.
  - Pack the k-th selected element into slot k; outNumValid = number selected (always >= 1).
  - nextCursor = last selected position + 1.
  - outLast = 1 when no mask bit is set at positions >= nextCursor.
  - On iready: go to IDLE if outLast, else cursor <= nextCursor.
- Handshake: a beat transfers on ovalid & iready. While ovalid & !iready, all outputs hold stable. ovalid never drops without a transfer, except on reset.
- Beats per block: 1 + ceil(nnz/NUM_OUTPUT). One IDLE cycle between blocks; no overlap of accept and emit.
- Boundaries:
  - nnz=0: bitmask beat only, with outLast=1.
  - nnz=BLOCK_LENGTH: BLOCK_LENGTH/NUM_OUTPUT full beats.
  - Odd remainder: final beat has outNumValid<NUM_OUTPUT and upper slots zero.
  - A set bit at position BLOCK_LENGTH-1 makes nextCursor = BLOCK_LENGTH; no overflow.
- Reset mid-block: the block is discarded, no partial beats follow, and the next cycle is IDLE.
- ivalid while not in IDLE is ignored; denseBlock is not sampled.

Optional Feature:
SPARSE_ENCODER_STATS_EN
- Defined: adds outputs statNumBlocks[31:0] and statNumNonZero[31:0], both zeroed by reset.
  - statNumBlocks increments by 1 per accepted block.
  - statNumNonZero adds the popcount of the mask at acceptance.
  - Both wrap modulo 2^32.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: hold reset 3 cycles with ivalid=1 -> oready=0 and ovalid=0 throughout; oready=1 the cycle after release; no beats emitted.
- All-zero block -> single beat: outIsBitmask=1, outBitmask=0x0000, outLast=1; oready=1 again the following cycle.
- Elements 2=0x05, 9=0x7F, rest 0 ->
  - Beat 1: outBitmask=0x0204.
  - Beat 2: outData=0x7F05, outNumValid=2, outLast=1.
- Elements 0=0x11, 5=0x22, 15=0x33 ->
  - Beat 1: mask 0x8021.
  - Beat 2: data 0x2211, n=2, last=0.
  - Beat 3: data 0x0033, n=1, last=1.
- Elements i = i+1 for all 16, with iready toggling 0/1 every cycle ->
  - Mask 0xFFFF, then 8 data beats; data beat k (k=1..8) = {2k, 2k-1}.
  - outLast only on data beat 8.
  - Outputs stable during every stall.
- Same stimulus as the previous scenario, with reset asserted during data beat 3 -> ovalid=0 next cycle; a following block (elements 2=0x05, 9=0x7F) encodes correctly. With SPARSE_ENCODER_STATS_EN: stats are 1 block and 2 non-zero after it.

Source files
------------

// File: rtl/sparse_block_encoder.sv
// Bitmask-compressed block encoder: one bitmask beat, then non-zero elements packed NUM_OUTPUT per beat.
// Optional statistics counters are enabled by defining SPARSE_ENCODER_STATS_EN.
module sparse_block_encoder #(
    parameter int BLOCK_LENGTH   = 16,
    parameter int ELEMENT_WIDTH  = 8,
    parameter int NUM_OUTPUT     = 2,
    parameter int INDEX_BITWIDTH = 5,
    parameter int COUNT_BITWIDTH = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                ivalid,
    output logic                                oready,
    input  logic [ELEMENT_WIDTH*BLOCK_LENGTH-1:0] denseBlock,
    output logic                                ovalid,
    input  logic                                iready,
    output logic                                outIsBitmask,
    output logic                                outLast,
    output logic [BLOCK_LENGTH-1:0]             outBitmask,
    output logic [ELEMENT_WIDTH*NUM_OUTPUT-1:0] outData,
    output logic [COUNT_BITWIDTH-1:0]           outNumValid
`ifdef SPARSE_ENCODER_STATS_EN
    ,
    output logic [31:0]                         statNumBlocks,
    output logic [31:0]                         statNumNonZero
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MASK = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]                              r_state;
    logic [ELEMENT_WIDTH*BLOCK_LENGTH-1:0]   r_block;
    logic [BLOCK_LENGTH-1:0]                 r_mask;
    logic [INDEX_BITWIDTH-1:0]               r_cursor;

    logic [BLOCK_LENGTH-1:0]                 w_mask_in;
    logic [ELEMENT_WIDTH*NUM_OUTPUT-1:0]     w_sel_data;
    logic [COUNT_BITWIDTH-1:0]               w_sel_cnt;
    logic [INDEX_BITWIDTH-1:0]               w_next_cursor;
    logic                                    w_more;
    logic                                    w_data_last;

    always_comb begin
        w_mask_in = '0;
        for (int unsigned i = 0; i < BLOCK_LENGTH; i++) begin
            w_mask_in[i] = |denseBlock[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
    end

    // Any set bit still found after the slots are full means another beat follows.
    always_comb begin
        int unsigned v_cnt;
        int unsigned v_last;
        w_sel_data = '0;
        w_more     = 1'b0;
        v_cnt      = 0;
        v_last     = 0;
        for (int unsigned i = 0; i < BLOCK_LENGTH; i++) begin
            if (r_mask[i] && (i >= 32'(r_cursor))) begin
                if (v_cnt < NUM_OUTPUT) begin
                    w_sel_data[v_cnt*ELEMENT_WIDTH +: ELEMENT_WIDTH] = r_block[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                    v_cnt  = v_cnt + 1;
                    v_last = i;
                end else begin
                    w_more = 1'b1;
                end
            end
        end
        w_sel_cnt     = COUNT_BITWIDTH'(v_cnt);
        w_next_cursor = INDEX_BITWIDTH'(v_last + 32'd1);
    end

    assign w_data_last = !w_more;

    always_comb begin
        oready       = (r_state == S_IDLE) && !reset;
        ovalid       = (r_state == S_MASK) || (r_state == S_DATA);
        outIsBitmask = (r_state == S_MASK);
        outBitmask   = '0;
        outData      = '0;
        outNumValid  = '0;
        outLast      = 1'b0;
        if (r_state == S_MASK) begin
            outBitmask = r_mask;
            outLast    = (r_mask == '0);
        end else if (r_state == S_DATA) begin
            outData     = w_sel_data;
            outNumValid = w_sel_cnt;
            outLast     = w_data_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_block  <= '0;
            r_mask   <= '0;
            r_cursor <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ivalid) begin
                        r_block  <= denseBlock;
                        r_mask   <= w_mask_in;
                        r_cursor <= '0;
                        r_state  <= S_MASK;
                    end
                end
                S_MASK: begin
                    if (iready) begin
                        r_state <= (r_mask == '0) ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (iready) begin
                        if (w_data_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cursor <= w_next_cursor;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SPARSE_ENCODER_STATS_EN
    logic [31:0] r_stat_blocks;
    logic [31:0] r_stat_nnz;
    logic [31:0] w_popcnt;

    always_comb begin
        w_popcnt = '0;
        for (int unsigned i = 0; i < BLOCK_LENGTH; i++) begin
            w_popcnt = w_popcnt + 32'(w_mask_in[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_blocks <= '0;
            r_stat_nnz    <= '0;
        end else if ((r_state == S_IDLE) && ivalid) begin
            r_stat_blocks <= r_stat_blocks + 32'd1;
            r_stat_nnz    <= r_stat_nnz + w_popcnt;
        end
    end

    assign statNumBlocks  = r_stat_blocks;
    assign statNumNonZero = r_stat_nnz;
`endif

endmodule

// File: tb/tb_sparse_block_encoder.sv
// Scoreboard bench for sparse_block_encoder: a queue-based reference model predicts every beat.
module tb_sparse_block_encoder;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ivalid = 1'b0;
    logic         oready;
    logic [127:0] denseBlock = '0;
    logic         ovalid;
    logic         iready = 1'b0;
    logic         outIsBitmask;
    logic         outLast;
    logic [15:0]  outBitmask;
    logic [15:0]  outData;
    logic [1:0]   outNumValid;
`ifdef SPARSE_ENCODER_STATS_EN
    logic [31:0]  statNumBlocks;
    logic [31:0]  statNumNonZero;
`endif

    sparse_block_encoder #(
        .BLOCK_LENGTH(16), .ELEMENT_WIDTH(8), .NUM_OUTPUT(2),
        .INDEX_BITWIDTH(5), .COUNT_BITWIDTH(2)
    ) dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
        .denseBlock(denseBlock), .ovalid(ovalid), .iready(iready),
        .outIsBitmask(outIsBitmask), .outLast(outLast), .outBitmask(outBitmask),
        .outData(outData), .outNumValid(outNumValid)
`ifdef SPARSE_ENCODER_STATS_EN
        , .statNumBlocks(statNumBlocks), .statNumNonZero(statNumNonZero)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        is_mask;
        logic        last;
        logic [15:0] bm;
        logic [15:0] data;
        logic [1:0]  n;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_xfer = 0;
    int    ready_mode = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: list the non-zero values in order, then cut the list into pairs.
    task automatic push_expected(input logic [127:0] blk);
        logic [7:0]  nz[$];
        logic [15:0] bm;
        logic [7:0]  e;
        beat_t       b;
        bm = '0;
        for (int i = 0; i < 16; i++) begin
            e = blk[i*8 +: 8];
            if (e != 8'h00) begin
                bm[i] = 1'b1;
                nz.push_back(e);
            end
        end
        b = '{1'b1, (nz.size() == 0), bm, 16'h0000, 2'd0};
        exp_q.push_back(b);
        for (int j = 0; j < nz.size(); j += 2) begin
            b.is_mask = 1'b0;
            b.bm      = '0;
            b.data    = {((j + 1 < nz.size()) ? nz[j+1] : 8'h00), nz[j]};
            b.n       = (j + 1 < nz.size()) ? 2'd2 : 2'd1;
            b.last    = (j + 2 >= nz.size());
            exp_q.push_back(b);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       iready = 1'($urandom_range(0, 1));
                1:       iready = ~iready;
                default: iready = 1'b1;
            endcase
        end
    end

    beat_t mon_act;
    beat_t mon_snap;
    bit    mon_pending = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset && ovalid) begin
                mon_act = '{outIsBitmask, outLast, outBitmask, outData, outNumValid};
                if (mon_pending) check("stall_hold", mon_act, mon_snap);
                if (iready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got %0h expected none", mon_act);
                    end else begin
                        check("beat", mon_act, exp_q.pop_front());
                    end
                    n_xfer++;
                    mon_pending = 1'b0;
                end else begin
                    mon_snap    = mon_act;
                    mon_pending = 1'b1;
                end
            end else begin
                if (mon_pending && !reset) check("valid_hold", ovalid, 1);
                mon_pending = 1'b0;
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [127:0] blk);
        int t;
        t = 0;
        while (!oready && t < 200) begin
            cycle();
            t++;
        end
        if (!oready) begin
            check("send_timeout", 0, 1);
            return;
        end
        ivalid     = 1'b1;
        denseBlock = blk;
        push_expected(blk);
        cycle();
        ivalid     = 1'b0;
        denseBlock = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !oready) && t < 500) begin
            cycle();
            t++;
        end
        check(name, (t < 500), 1);
    endtask

    logic [127:0] blk;
    logic [127:0] blk_full;
    int           start_x;
    int           tmo;
    int           dens;

    initial begin
        // reset held with ivalid high
        reset      = 1'b1;
        ivalid     = 1'b1;
        denseBlock = {16{8'hA5}};
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("reset_oready", oready, 0);
            check("reset_ovalid", ovalid, 0);
        end
        reset  = 1'b0;
        ivalid = 1'b0;
        #1;
        check("release_oready", oready, 1);
        cycle();
        check("release_no_beat", ovalid, 0);

        // all-zero block
        send('0);
        check("busy_oready", oready, 0);
        cycle();
        check("zero_block_oready", oready, 1);
        wait_done("zero_done");

        // two sparse elements
        blk = '0;
        blk[2*8 +: 8] = 8'h05;
        blk[9*8 +: 8] = 8'h7F;
        send(blk);
        wait_done("two_elem_done");

        // odd remainder with the top position set
        blk = '0;
        blk[0*8 +: 8]  = 8'h11;
        blk[5*8 +: 8]  = 8'h22;
        blk[15*8 +: 8] = 8'h33;
        send(blk);
        wait_done("three_elem_done");

        // dense block with iready toggling
        for (int i = 0; i < 16; i++) blk_full[i*8 +: 8] = 8'(i + 1);
        ready_mode = 1;
        send(blk_full);
        wait_done("dense_done");

        // randomized blocks, random backpressure
        ready_mode = 0;
        for (int k = 0; k < 14; k++) begin
            dens = $urandom_range(0, 100);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 99) < dens) blk[i*8 +: 8] = 8'($urandom_range(1, 255));
                else blk[i*8 +: 8] = 8'h00;
            end
            send(blk);
        end
        wait_done("random_done");

        // reset during data beat 3 of a dense block
        ready_mode = 1;
        start_x    = n_xfer;
        send(blk_full);
        tmo = 0;
        while (n_xfer < start_x + 3 && tmo < 500) begin
            cycle();
            tmo++;
        end
        check("reach_beat3", (tmo < 500), 1);
        reset = 1'b1;
        cycle();
        check("midreset_ovalid", ovalid, 0);
        check("midreset_oready", oready, 0);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_idle", oready, 1);
`ifdef SPARSE_ENCODER_STATS_EN
        check("stats_blocks_reset", statNumBlocks, 0);
        check("stats_nnz_reset", statNumNonZero, 0);
`endif
        blk = '0;
        blk[2*8 +: 8] = 8'h05;
        blk[9*8 +: 8] = 8'h7F;
        send(blk);
        wait_done("post_reset_done");
`ifdef SPARSE_ENCODER_STATS_EN
        check("stats_blocks", statNumBlocks, 1);
        check("stats_nnz", statNumNonZero, 2);
`endif

        ready_mode = 2;
        repeat (5) cycle();
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
